// File: rtl/note_pkg.sv
// Shared definitions for the note playback path.
// Holds the note memory geometry, the rest code and the 2-bit playback
// state encoding. The tone generator debug view uses the same encoding.
package note_pkg;

  localparam int ADDR_W = 6;   // note memory address width (64 entries)
  localparam int NOTE_W = 8;   // stored note code width

  localparam logic [NOTE_W-1:0] REST = '0;  // code 0 = silence

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/tick_timer.sv
// Hold-time down-counter for the note player.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - synchronous active-low reset
//   load_i     - load load_val_i into the counter (wins over en_i)
//   load_val_i - value loaded on load_i
//   en_i       - count down while enabled
//   expired_o  - count has reached 0 while enabled
module tick_timer #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/note_player.sv
// Note playback stage. Walks the note memory from address 0 to
// note_count-1, holding each note on note_out for NOTE_TICKS cycles,
// optionally looping, and aborting on stop.
// Ports:
//   clock      - clock, rising edge
//   reset      - synchronous active-low reset
//   play       - start request (only looked at while idle)
//   stop       - abort request
//   loop_en    - restart at address 0 after the last note
//   note_count - number of recorded notes, 0 = empty
//   mem_data   - note memory read data, one cycle after RE
//   read_addr  - note memory read address
//   RE         - note memory read enable
//   note_out   - note code to the tone generator
//   note_valid - note_out is meaningful
//   busy       - playback in progress
//   done       - one-cycle pulse on normal end of playback
//
// state | meaning
// IDLE  | waiting for play
// FETCH | RE asserted at read_addr
// LATCH | mem_data captured into note_out, hold timer loaded
// HOLD  | note held until the timer expires
module note_player #(
  parameter int TICK_W     = 24,
  parameter int NOTE_TICKS = 12_500_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          stop,
  input  logic                          loop_en,
  input  logic [note_pkg::ADDR_W-1:0]   note_count,
  input  logic [note_pkg::NOTE_W-1:0]   mem_data,
  output logic [note_pkg::ADDR_W-1:0]   read_addr,
  output logic                          RE,
  output logic [note_pkg::NOTE_W-1:0]   note_out,
  output logic                          note_valid,
  output logic                          busy,
  output logic                          done
);

  import note_pkg::*;

  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [TICK_W-1:0] HOLD_LAST = TICK_W'(NOTE_TICKS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic                tmr_load, tmr_en, tmr_expired;

  tick_timer #(.W(TICK_W)) u_tick_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (HOLD_LAST),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      note_q  <= REST;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    note_d   = note_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    // stop outranks both play and the hold expiry
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play && !stop) begin
            if (note_count != '0) begin
              count_d = note_count;
              addr_d  = '0;
              state_d = FETCH;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        FETCH: state_d = LATCH;
        LATCH: begin
          note_d   = mem_data;
          valid_d  = 1'b1;
          tmr_load = 1'b1;
          state_d  = HOLD;
        end
        HOLD: begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            if (addr_q != (count_q - ONE_A)) begin
              addr_d  = addr_q + ONE_A;
              state_d = FETCH;
            end else if (loop_en && (note_count != '0)) begin
              // note_count is only re-sampled at the wrap
              addr_d  = '0;
              count_d = note_count;
              state_d = FETCH;
            end else begin
              if (loop_en) count_d = note_count;
              state_d = IDLE;
              done_d  = 1'b1;
              valid_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // note_out keeps the previous note through FETCH/LATCH so there is no gap
  assign read_addr  = addr_q;
  assign RE         = (state_q == FETCH);
  assign note_out   = note_q;
  assign note_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: doc/note_player.md
# note_player

Playback stage downstream of the note writer. It reads the recorded notes from the shared 64-entry note memory, in order from address 0 up to the writer's current write address minus 1. It presents each note to the tone generator for a fixed number of clock ticks. It can loop over the recorded notes, and it stops on request.

## Interface
Parameters:
- ADDR_W, 6: note memory address width; matches the writer's write address.
- NOTE_W, 8: stored note code width; code 0 means rest (silence).
- TICK_W, 24: hold-counter width.
- NOTE_TICKS, 12_500_000: clock cycles each note is held (0.25 s at 50 MHz); must be ≥1.

Ports:
- clock, in, 1: single clock; everything is on the rising edge.
- reset, in, 1: synchronous, active-low reset.
- play, in, 1: start request, sampled only in IDLE.
- stop, in, 1: abort request, accepted in any state.
- loop_en, in, 1: restart from address 0 after the last note.
- note_count, in, ADDR_W: number of recorded notes (the writer's write address); 0 means empty.
- mem_data, in, NOTE_W: synchronous RAM read data, valid 1 cycle after RE.
- read_addr, out, ADDR_W: memory read address.
- RE, out, 1: memory read enable, 1-cycle pulse.
- note_out, out, NOTE_W: current note to the tone generator.
- note_valid, out, 1: note_out is meaningful.
- busy, out, 1: playback in progress.
- done, out, 1: 1-cycle pulse when playback ends normally.

## Operation
FSM states: IDLE, FETCH, LATCH, HOLD.

- **Reset** (reset=0): state=IDLE, read_addr=0, RE=0, note_out=0, note_valid=0, busy=0, done=0, internal count latch=0, tick counter=0.
- **IDLE**
  - play=1 and note_count≠0: latch note_count into count_q, set read_addr=0, go to FETCH.
  - play=1 and note_count=0: pulse done for 1 cycle; stay in IDLE.
- **FETCH**: RE=1 for this cycle with read_addr; go to LATCH.
- **LATCH**: note_out←mem_data, note_valid←1, tick counter←NOTE_TICKS−1; go to HOLD.
- **HOLD**: decrement the tick counter. At 0:
  - If read_addr≠count_q−1: read_addr+1, go to FETCH.
  - Else if loop_en=1: read_addr←0, re-latch count_q←note_count (if that value is 0, end as below), go to FETCH.
  - Else: go to IDLE, pulse done, note_valid←0.
- **Between notes**: note_valid stays 1 and note_out holds the previous note until the next LATCH, so the output has no gap.
- **stop=1** in any non-IDLE state: next cycle state=IDLE, note_valid=0, RE=0, no done pulse. stop has priority over play and over the HOLD expiry in the same cycle.
- **play while busy** is ignored.
- **Changes to note_count** during a pass (the writer is still recording) do not take effect until the next loop wrap or the next play.
- **Note code 0** is passed through unchanged with note_valid=1; the tone generator treats it as a rest.
- **Widths**: read_addr+1 never exceeds count_q−1 ≤ 62, so no wrap occurs. A note_count of 64 notes is not representable: the writer wraps to 0, which reads as empty.
- **reset=0 mid-playback** forces the reset values on the next edge.

## Timing
- play accepted at edge N: busy=1, RE=1, read_addr=0 at N+1; note_out valid at N+2 (after LATCH); first note held through N+2+NOTE_TICKS.
- Period per note: NOTE_TICKS+2 cycles (FETCH + LATCH + hold).
- done is asserted on the cycle busy drops.
- busy=1 exactly while state≠IDLE.

## Structure
- Shared package `note_pkg` holds:
  - ADDR_W, NOTE_W, and the REST code (0);
  - the FSM state encoding (2-bit: IDLE=0, FETCH=1, LATCH=2, HOLD=3), shared with the tone generator debug view.
- One sub-module, `tick_timer`, implements the hold counter:
  - inputs: load, load value, enable;
  - output: expired, when count=0 and enabled.
- The FSM and address logic stay in note_player.

## Test plan
All scenarios use NOTE_TICKS=4 and a memory model with 1-cycle read latency.

- **Plain playback**: memory [0..2]=0x11,0x22,0x33, note_count=3, loop_en=0, play pulse → note_out sequence 0x11, 0x22, 0x33, each held 6 cycles; done pulses once; busy 0 afterwards; RE pulses at addresses 0, 1, 2.
- **Empty**: note_count=0, play → done pulses on the next cycle; busy, RE and note_valid stay 0.
- **Loop**: note_count=2, loop_en=1 → sequence 0x11, 0x22, 0x11, 0x22…; no done pulse. Then stop → note_valid=0 and busy=0 one cycle later, no done pulse.
- **Simultaneous events**: stop in the same cycle as the HOLD expiry of the last note → IDLE with no done pulse. play during busy → no restart and read_addr unaffected.
- **note_count change**: note_count changes 3→5 mid-pass with loop_en=1 → the first pass plays 3 notes, the second pass plays 5.
- **Reset mid-operation**: reset=0 during HOLD → all outputs return to their reset values on the next edge. A subsequent play starts again at address 0.
